pipeline_latch_chain: RTL and testbench
=======================================

# pipeline_latch_chain

Parametrised chain of pipeline latches with per-stage valid bits, hazard stall with bubble injection, branch flush and cycle/retire counters. It replaces the hand-wired IF/ID, ID/EX, EX/MEM and MEM/WB buses between the fetch, decode, execute, memory and writeBack stages of the pipelined MIPS core. It sits between the stage datapaths: each stage drives its payload in and reads its latched copy out.

## Interface
Parameters:
- WIDTH, 148: payload bits per stage. Set to the widest latch; narrower stages leave the upper bits unused.
- STAGES, 4: number of latches. Index 0 = IF/ID, index STAGES-1 = MEM/WB.
- STALL_STAGE, 1: first latch that receives a bubble on stall. Legal range 1 ≤ STALL_STAGE < STAGES.
- FLUSH_DEPTH, 3: number of youngest latches squashed on flush. Legal range 1 ≤ FLUSH_DEPTH ≤ STAGES.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents a real instruction
- in_data  in  WIDTH  fetch payload
- stage_in  in  STAGES*WIDTH  payload each stage computes from its latched input. Slice k feeds latch k+1; slice STAGES-1 is unused.
- stall  in  1  load-use hazard request
- flush  in  1  taken branch resolved
- in_ready  out  1  fetch may advance the PC; equals !stall || flush
- stage_data  out  STAGES*WIDTH  latched payloads; slice k = latch k
- stage_valid  out  STAGES  per-latch valid
- cycle_count  out  32  clocks since reset
- retired_count  out  32  valid entries that left latch STAGES-1

## Operation
- Normal edge:
  - latch 0 ← {in_valid, in_valid ? in_data : 0}
  - latch k ← {stage_valid[k-1], stage_in slice k-1}
- Bubble: valid = 0, data = all zeros. A latch never holds nonzero data while invalid.
- Stall (flush low):
  - latches 0..STALL_STAGE-1 hold their contents
  - latch STALL_STAGE loads a bubble
  - latches above STALL_STAGE advance normally
- Flush:
  - latches 0..FLUSH_DEPTH-1 load bubbles
  - latches FLUSH_DEPTH and above advance normally, so latch FLUSH_DEPTH receives the branch itself
- Flush and stall together: flush wins and stall is ignored that cycle; in_ready = 1 so fetch loads the branch target.
- cycle_count increments on every edge and wraps 0xFFFFFFFF → 0.
- retired_count increments on every edge where stage_valid[STAGES-1] = 1 before the edge. It wraps the same way.
- Reset asserted (any time, including mid-stall or mid-flush):
  - all valid bits, all data and both counters clear immediately
  - operation resumes at the first rising edge after reset deasserts

## Timing
- Latency from an accepted in_valid to stage_valid[STAGES-1] is STAGES edges, plus one edge per stall cycle while the entry sits below STALL_STAGE.
- Throughput: one entry per cycle when stall = 0.
- in_ready is combinational from stall and flush. All other outputs are registered.
- Reset values: stage_valid = 0, stage_data = 0, cycle_count = 0, retired_count = 0. in_ready follows its inputs (1 when both are low).
- A stall lasting N cycles inserts exactly N bubbles at latch STALL_STAGE and holds the older entries for N cycles.
- A flush lasts one cycle per assertion. Back-to-back flushes each squash FLUSH_DEPTH latches.

## Structure
- Package pipe_pkg holds:
  - stage index constants: IF_ID = 0, ID_EX = 1, EX_MEM = 2, MEM_WB = 3
  - default WIDTH constant
  - per-stage field offsets (WB, M, EX, pc, data1, data2, ext, rt, rd) used by the stages to slice payloads
- Sub-module pipe_stage_reg holds one latch: async-low reset, hold / bubble / load select, WIDTH-wide data and valid. Instantiate it STAGES times in a generate loop.
- The top level computes the per-latch hold and bubble selects and the two counters.

## Test plan
- Reset release, in_valid = 1, in_data = 0x01..0x06 on successive edges, stage_in = latched value + 0x100 per hop → stage_valid[3] first rises at edge 4 carrying 0x301. retired_count = 3 after edge 7.
- Stall held for 2 edges while latch 0 holds 0x05 → latch 0 stays 0x05 for both edges, latch 1 shows two bubbles, in_ready = 0, older entries keep draining.
- Flush with latches holding A, B, C, D (latch 0..3) → next edge latches 0–2 are invalid and zero, latch 3 = C's stage_in slice, in_valid data that cycle is discarded.
- Stall and flush asserted together → identical result to flush alone, in_ready = 1.
- reset pulled low mid-stream between edges → all outputs read 0 before the next edge and stay 0 until release.
- Force cycle_count to 0xFFFFFFFE, run 3 edges → sequence 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/pipeline_latch_chain_pkg.sv
// pipe_pkg: shared constants for the IF/ID..MEM/WB latch chain and the stages that slice its payloads.
package pipe_pkg;
  localparam int IF_ID = 0;
  localparam int ID_EX = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;
  localparam int DEFAULT_WIDTH = 148;
  localparam int DEFAULT_STAGES = 4;
  // Field layout of the widest (ID/EX) payload, LSB first.
  localparam int RD_OFF = 0;
  localparam int RD_W = 5;
  localparam int RT_OFF = 5;
  localparam int RT_W = 5;
  localparam int EXT_OFF = 10;
  localparam int EXT_W = 32;
  localparam int DATA2_OFF = 42;
  localparam int DATA2_W = 32;
  localparam int DATA1_OFF = 74;
  localparam int DATA1_W = 32;
  localparam int PC_OFF = 106;
  localparam int PC_W = 32;
  localparam int EX_OFF = 138;
  localparam int EX_W = 5;
  localparam int M_OFF = 143;
  localparam int M_W = 3;
  localparam int WB_OFF = 146;
  localparam int WB_W = 2;
  typedef enum logic [1:0] {SEL_LOAD, SEL_HOLD, SEL_BUBBLE} sel_e;
endpackage

// File: rtl/pipeline_latch_chain_if.sv
// pipeline_latch_chain_if: fetch inputs, stage feedback and latched outputs of the latch chain.
interface pipeline_latch_chain_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic [STAGES*WIDTH-1:0] stage_in;
  logic stall;
  logic flush;
  logic in_ready;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic [STAGES-1:0] stage_valid;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
  modport master (
    output in_valid, in_data, stage_in, stall, flush,
    input in_ready, stage_data, stage_valid, cycle_count, retired_count
  );
  modport slave (
    input in_valid, in_data, stage_in, stall, flush,
    output in_ready, stage_data, stage_valid, cycle_count, retired_count
  );
endinterface

// File: rtl/pipeline_latch_chain_stage_reg.sv
// pipe_stage_reg: one pipeline latch with hold, bubble and load selects; data is zero whenever invalid.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  sel_e             sel,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid <= 1'b0;
      data <= '0;
    end else if (sel == SEL_BUBBLE) begin
      valid <= 1'b0;
      data <= '0;
    end else if (sel == SEL_LOAD) begin
      valid <= valid_d;
      data <= valid_d ? data_d : '0;
    end
endmodule

// File: rtl/pipeline_latch_chain.sv
// pipeline_latch_chain: IF/ID..MEM/WB latches with stall bubbles, branch flush and cycle/retire counters.
module pipeline_latch_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES,
  parameter int STALL_STAGE = 1,
  parameter int FLUSH_DEPTH = 3
) (
  input logic clk,
  input logic reset,
  pipeline_latch_chain_if.slave bus
);
  logic [STAGES-1:0] valid_q;
  logic [STAGES*WIDTH-1:0] data_q;
  logic [31:0] cycle_q;
  logic [31:0] retired_q;
  logic unused_top_slice;
  assign unused_top_slice = ^bus.stage_in[(STAGES-1)*WIDTH +: WIDTH];
  assign bus.in_ready = !bus.stall || bus.flush;
  assign bus.stage_valid = valid_q;
  assign bus.stage_data = data_q;
  assign bus.cycle_count = cycle_q;
  assign bus.retired_count = retired_q;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sel_e sel;
    logic valid_d;
    logic [WIDTH-1:0] data_d;
    // Flush overrides stall; under stall the older latches above the bubble keep draining.
    assign sel = bus.flush ? (k < FLUSH_DEPTH ? SEL_BUBBLE : SEL_LOAD)
               : !bus.stall ? SEL_LOAD
               : k < STALL_STAGE ? SEL_HOLD
               : k == STALL_STAGE ? SEL_BUBBLE : SEL_LOAD;
    if (k == 0) begin : g_head
      assign valid_d = bus.in_valid;
      assign data_d = bus.in_data;
    end else begin : g_body
      assign valid_d = valid_q[k-1];
      assign data_d = bus.stage_in[(k-1)*WIDTH +: WIDTH];
    end
    pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
      .clk(clk),
      .reset(reset),
      .sel(sel),
      .valid_d(valid_d),
      .data_d(data_d),
      .valid(valid_q[k]),
      .data(data_q[k*WIDTH +: WIDTH])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycle_q <= '0;
      retired_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      retired_q <= retired_q + {31'd0, valid_q[STAGES-1]};
    end
endmodule

// File: tb/tb_pipeline_latch_chain.sv
// tb_pipeline_latch_chain: table, directed and randomized checks of the latch chain against a queue-style model.
module tb_pipeline_latch_chain;
  import pipe_pkg::*;
  localparam int W = DEFAULT_WIDTH;
  localparam int S = 4;
  localparam int SS = 1;
  localparam int FD = 3;
  localparam int CW = S * W;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  pipeline_latch_chain_if #(.WIDTH(W), .STAGES(S)) bus ();
  pipeline_latch_chain #(.WIDTH(W), .STAGES(S), .STALL_STAGE(SS), .FLUSH_DEPTH(FD)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  logic [W-1:0] add;
  always_comb begin
    bus.stage_in = '0;
    for (int k = 0; k < S; k++) bus.stage_in[k*W +: W] = bus.stage_data[k*W +: W] + add;
  end
  logic mv[S];
  logic [W-1:0] md[S];
  logic [31:0] m_cyc, m_ret;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic iv;
    logic [7:0] id;
    logic v3;
    logic [15:0] d3;
    logic [31:0] ret;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < S; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    m_cyc = '0;
    m_ret = '0;
  endtask

  // Each entry moves one slot per edge, picking up +add per hop; stall/flush rewrite slots afterwards.
  task automatic model_edge();
    logic nv[S];
    logic [W-1:0] nd[S];
    for (int k = 0; k < S; k++) begin
      nv[k] = (k == 0) ? bus.in_valid : mv[k-1];
      nd[k] = (k == 0) ? (bus.in_valid ? bus.in_data : '0) : (mv[k-1] ? md[k-1] + add : '0);
      if (bus.flush ? k < FD : bus.stall && k == SS) begin
        nv[k] = 1'b0;
        nd[k] = '0;
      end else if (!bus.flush && bus.stall && k < SS) begin
        nv[k] = mv[k];
        nd[k] = md[k];
      end
    end
    m_ret = m_ret + (mv[S-1] ? 32'd1 : 32'd0);
    m_cyc = m_cyc + 32'd1;
    for (int k = 0; k < S; k++) begin
      mv[k] = nv[k];
      md[k] = nd[k];
    end
  endtask

  task automatic check_all(input string tag);
    logic [S-1:0] ev;
    logic [CW-1:0] ed;
    for (int k = 0; k < S; k++) begin
      ev[k] = mv[k];
      ed[k*W +: W] = md[k];
    end
    chk({tag, ".valid"}, CW'(bus.stage_valid), CW'(ev));
    chk({tag, ".data"}, bus.stage_data, ed);
    chk({tag, ".cycle"}, CW'(bus.cycle_count), CW'(m_cyc));
    chk({tag, ".retired"}, CW'(bus.retired_count), CW'(m_ret));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    add = W'(32'h100);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    model_clear();
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic feed(input int n);
    for (int i = 1; i <= n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(i);
      step("feed");
    end
  endtask

  task automatic flush_case(input string tag, input logic with_stall);
    do_reset();
    feed(4);
    bus.flush = 1'b1;
    bus.stall = with_stall;
    bus.in_valid = 1'b1;
    bus.in_data = W'(32'h77);
    #1;
    chk({tag, ".in_ready"}, CW'(bus.in_ready), CW'(1'b1));
    step(tag);
    chk({tag, ".v"}, CW'(bus.stage_valid), CW'(4'b1000));
    chk({tag, ".low_zero"}, CW'(bus.stage_data[3*W-1:0]), CW'(0));
    chk({tag, ".d3"}, CW'(bus.stage_data[3*W +: W]), CW'(32'h302));
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_clear();
    #1;
    check_all("por");
    chk("por.in_ready", CW'(bus.in_ready), CW'(1'b1));
    @(negedge clk);
    reset = 1'b1;
    // Fill: entry i enters latch 0 at edge i and picks up 0x100 per hop.
    for (int i = 0; i < 7; i++) begin
      tbl[i].iv = (i < 6);
      tbl[i].id = (i < 6) ? 8'(i + 1) : 8'h0;
      tbl[i].v3 = (i >= 3);
      tbl[i].d3 = (i >= 3) ? 16'(32'h300 + i - 2) : 16'h0;
      tbl[i].ret = (i >= 4) ? 32'(i - 3) : 32'd0;
    end
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = tbl[i].iv;
      bus.in_data = W'(tbl[i].id);
      step("tbl");
      chk("tbl.v3", CW'(bus.stage_valid[3]), CW'(tbl[i].v3));
      chk("tbl.d3", CW'(bus.stage_data[3*W +: W]), CW'(tbl[i].d3));
      chk("tbl.ret", CW'(bus.retired_count), CW'(tbl[i].ret));
    end
    do_reset();
    feed(5);
    bus.stall = 1'b1;
    bus.in_data = W'(6);
    #1;
    chk("stall.in_ready", CW'(bus.in_ready), CW'(1'b0));
    for (int n = 0; n < 2; n++) begin
      step("stall");
      chk("stall.l0", CW'(bus.stage_data[W-1:0]), CW'(5));
      chk("stall.l1", CW'(bus.stage_valid[1:0]), CW'(2'b01));
    end
    chk("stall.l3", CW'(bus.stage_data[3*W +: W]), CW'(32'h304));
    bus.stall = 1'b0;
    step("unstall");
    chk("unstall.l1", CW'(bus.stage_data[W +: W]), CW'(32'h105));
    flush_case("flush", 1'b0);
    flush_case("flush_stall", 1'b1);
    do_reset();
    feed(3);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    feed(2);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    m_cyc = 32'hFFFF_FFFE;
    chk("wrap.pre", CW'(bus.cycle_count), CW'(32'hFFFF_FFFE));
    step("wrap1");
    chk("wrap.ff", CW'(bus.cycle_count), CW'(32'hFFFF_FFFF));
    step("wrap2");
    chk("wrap.zero", CW'(bus.cycle_count), CW'(0));
    step("wrap3");
    chk("wrap.one", CW'(bus.cycle_count), CW'(1));
    do_reset();
    repeat (400) begin
      bus.in_valid = 1'($urandom);
      bus.in_data = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      add = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      #1;
      chk("rnd.in_ready", CW'(bus.in_ready), CW'(!bus.stall || bus.flush));
      step("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
